// File: rtl/riscv_pkg.sv
// Shared RISC-V core package: data width, register index type, starvation
// FSM encoding and the buffered MDU result record.
package riscv_pkg;

  localparam int unsigned XLEN       = 64;
  localparam int unsigned REG_IDX_W  = 5;
  localparam int unsigned BUSY_CNT_W = 3;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;

  typedef enum logic [0:0] {
    NORMAL      = 1'b0,
    FORCE_DRAIN = 1'b1
  } starve_state_t;

  typedef struct packed {
    reg_idx_t        rd;
    logic [XLEN-1:0] data;
  } mdu_res_t;

  // True for any architectural register other than x0.
  function automatic logic reg_nz(input reg_idx_t idx);
    return idx != {REG_IDX_W{1'b0}};
  endfunction

endpackage

// File: rtl/regfile_wb_scheduler_if.sv
// Bundle of issue, writeback, MDU result and register-file write signals.
// Optional bypass outputs exist only when RF_SCHED_BYPASS_EN is defined.
interface regfile_wb_scheduler_if;
  import riscv_pkg::*;

  logic                  issue_valid;
  reg_idx_t              issue_rs1;
  reg_idx_t              issue_rs2;
  reg_idx_t              issue_rd;
  logic                  issue_long;
  logic                  issue_stall;
  logic                  wb_valid;
  reg_idx_t              wb_rd;
  logic [XLEN-1:0]       wb_data;
  logic                  mdu_res_valid;
  logic                  mdu_res_ready;
  reg_idx_t              mdu_res_rd;
  logic [XLEN-1:0]       mdu_res_data;
  logic                  rf_we;
  reg_idx_t              rf_rd;
  logic [XLEN-1:0]       rf_wdata;
  logic [BUSY_CNT_W-1:0] busy_cnt;

`ifdef RF_SCHED_BYPASS_EN
  logic                  byp1_hit;
  logic                  byp2_hit;
  logic [XLEN-1:0]       byp_data;

  modport master (
    output issue_valid, issue_rs1, issue_rs2, issue_rd, issue_long,
    output wb_valid, wb_rd, wb_data,
    output mdu_res_valid, mdu_res_rd, mdu_res_data,
    input  issue_stall, mdu_res_ready, rf_we, rf_rd, rf_wdata, busy_cnt,
    input  byp1_hit, byp2_hit, byp_data
  );

  modport slave (
    input  issue_valid, issue_rs1, issue_rs2, issue_rd, issue_long,
    input  wb_valid, wb_rd, wb_data,
    input  mdu_res_valid, mdu_res_rd, mdu_res_data,
    output issue_stall, mdu_res_ready, rf_we, rf_rd, rf_wdata, busy_cnt,
    output byp1_hit, byp2_hit, byp_data
  );
`else
  modport master (
    output issue_valid, issue_rs1, issue_rs2, issue_rd, issue_long,
    output wb_valid, wb_rd, wb_data,
    output mdu_res_valid, mdu_res_rd, mdu_res_data,
    input  issue_stall, mdu_res_ready, rf_we, rf_rd, rf_wdata, busy_cnt
  );

  modport slave (
    input  issue_valid, issue_rs1, issue_rs2, issue_rd, issue_long,
    input  wb_valid, wb_rd, wb_data,
    input  mdu_res_valid, mdu_res_rd, mdu_res_data,
    output issue_stall, mdu_res_ready, rf_we, rf_rd, rf_wdata, busy_cnt
  );
`endif

endinterface

// File: rtl/rf_sched_fifo.sv
// Small {rd,data} result FIFO. DEPTH must be a power of two; pointers carry
// one extra wrap bit to tell full from empty. Push while full is accepted
// when a pop happens in the same cycle.
module rf_sched_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned DW    = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [DW-1:0] wdata_i,
  output logic [DW-1:0] rdata_o,
  output logic          full_o,
  output logic          empty_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW:0]   wr_ptr_q;
  logic [AW:0]   rd_ptr_q;
  logic          do_push_s;
  logic          do_pop_s;

  assign empty_o   = (wr_ptr_q == rd_ptr_q);
  assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop_s  = pop_i && !empty_o;
  assign do_push_s = push_i && (!full_o || do_pop_s);
  assign rdata_o   = mem_q[rd_ptr_q[AW-1:0]];

  // Storage array: written at the tail on every accepted push
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (do_push_s) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end
  end

  // Head/tail pointers, wrapping naturally modulo DEPTH
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push_s) begin
        wr_ptr_q <= wr_ptr_q + {{AW{1'b0}}, 1'b1};
      end
      if (do_pop_s) begin
        rd_ptr_q <= rd_ptr_q + {{AW{1'b0}}, 1'b1};
      end
    end
  end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Register-file write-port owner. Pipeline WB has priority on the single
// write port; MDU results are buffered and drained into idle slots. A busy
// scoreboard tracks MDU destinations and stalls issue on RAW/WAW hazards.
// A starvation FSM force-stalls issue when a buffered result waits too long.
// Optional feature macro: RF_SCHED_BYPASS_EN (source bypass from the result
// being written this cycle).
module regfile_wb_scheduler
  import riscv_pkg::*;
#(
  parameter int unsigned MAX_OUT      = 4,
  parameter int unsigned FIFO_DEPTH   = 2,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input logic                   clk,
  input logic                   reset,
  regfile_wb_scheduler_if.slave bus
);

  localparam int unsigned SCW = $clog2(STARVE_LIMIT);
  localparam int unsigned RW  = $bits(mdu_res_t);

  logic [31:0]           busy_q, busy_d, set_mask_s, clr_mask_s;
  logic [BUSY_CNT_W-1:0] cnt_q, cnt_d;
  starve_state_t         state_q, state_d;
  logic [SCW-1:0]        starve_q, starve_d;
  logic [RW-1:0]         push_raw_s, head_raw_s;
  mdu_res_t              head_s;
  logic fifo_full_s, fifo_empty_s, ready_s, push_s, pop_s, wb_sel_s;
  logic head_live_s, head_wr_s, set_s, clr_s, accept_s, stall_s;
  logic hz_rs1_s, hz_rs2_s, hz_rd_s, byp1_s, byp2_s;

  assign push_raw_s  = {bus.mdu_res_rd, bus.mdu_res_data};
  assign head_s      = mdu_res_t'(head_raw_s);
  assign ready_s     = !fifo_full_s && !reset;
  assign push_s      = bus.mdu_res_valid && ready_s;
  assign wb_sel_s    = bus.wb_valid && reg_nz(bus.wb_rd);
  // Head leaves the buffer whenever the pipeline does not claim the port;
  // a head whose rd is not busy (stale or x0) is dropped without a write.
  assign pop_s       = !fifo_empty_s && !wb_sel_s && !reset;
  assign head_live_s = busy_q[head_s.rd] && reg_nz(head_s.rd);
  assign head_wr_s   = pop_s && head_live_s;
  assign accept_s    = bus.issue_valid && !stall_s;
  assign set_s       = accept_s && bus.issue_long && reg_nz(bus.issue_rd);
  assign clr_s       = head_wr_s;

  rf_sched_fifo #(
    .DEPTH (FIFO_DEPTH),
    .DW    (RW)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push_s),
    .pop_i   (pop_s),
    .wdata_i (push_raw_s),
    .rdata_o (head_raw_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s)
  );

`ifdef RF_SCHED_BYPASS_EN
  assign byp1_s       = head_wr_s && (head_s.rd == bus.issue_rs1);
  assign byp2_s       = head_wr_s && (head_s.rd == bus.issue_rs2);
  assign bus.byp1_hit = byp1_s;
  assign bus.byp2_hit = byp2_s;
  assign bus.byp_data = (byp1_s || byp2_s) ? head_s.data : {XLEN{1'b0}};
`else
  assign byp1_s = 1'b0;
  assign byp2_s = 1'b0;
`endif

  // Issue hazard detection and stall generation
  always_comb begin
    hz_rs1_s = busy_q[bus.issue_rs1] && reg_nz(bus.issue_rs1) && !byp1_s;
    hz_rs2_s = busy_q[bus.issue_rs2] && reg_nz(bus.issue_rs2) && !byp2_s;
    hz_rd_s  = busy_q[bus.issue_rd]  && reg_nz(bus.issue_rd);
    if (reset) begin
      stall_s = 1'b1;
    end else if (bus.issue_valid) begin
      stall_s = hz_rs1_s || hz_rs2_s || hz_rd_s ||
                (bus.issue_long && (cnt_q == BUSY_CNT_W'(MAX_OUT))) ||
                (state_q == FORCE_DRAIN);
    end else begin
      stall_s = 1'b0;
    end
  end

  // Write-port arbitration: pipeline WB first, then a live buffered result
  always_comb begin
    bus.rf_we    = 1'b0;
    bus.rf_rd    = {REG_IDX_W{1'b0}};
    bus.rf_wdata = {XLEN{1'b0}};
    if (reset) begin
      bus.rf_we = 1'b0;
    end else if (wb_sel_s) begin
      bus.rf_we    = 1'b1;
      bus.rf_rd    = bus.wb_rd;
      bus.rf_wdata = bus.wb_data;
    end else if (head_wr_s) begin
      bus.rf_we    = 1'b1;
      bus.rf_rd    = head_s.rd;
      bus.rf_wdata = head_s.data;
    end else begin
      bus.rf_we = 1'b0;
    end
  end

  // Scoreboard next state: set is applied after clear so set wins
  always_comb begin
    set_mask_s = set_s ? (32'd1 << bus.issue_rd) : 32'd0;
    clr_mask_s = clr_s ? (32'd1 << head_s.rd) : 32'd0;
    busy_d     = (busy_q & ~clr_mask_s) | set_mask_s;
    case ({set_s, clr_s})
      2'b10:   cnt_d = cnt_q + BUSY_CNT_W'(1);
      2'b01:   cnt_d = cnt_q - BUSY_CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Starvation FSM next state: count waiting cycles of an unserved head
  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    case (state_q)
      NORMAL: begin
        if (pop_s) begin
          starve_d = {SCW{1'b0}};
        end else if (!fifo_empty_s) begin
          if (starve_q == SCW'(STARVE_LIMIT - 1)) begin
            state_d = FORCE_DRAIN;
          end else begin
            starve_d = starve_q + SCW'(1);
          end
        end else begin
          starve_d = {SCW{1'b0}};
        end
      end
      FORCE_DRAIN: begin
        if (pop_s) begin
          state_d  = NORMAL;
          starve_d = {SCW{1'b0}};
        end else begin
          state_d  = FORCE_DRAIN;
        end
      end
      default: begin
        state_d  = NORMAL;
        starve_d = {SCW{1'b0}};
      end
    endcase
  end

  // State registers: scoreboard, in-flight count and starvation FSM
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q   <= 32'd0;
      cnt_q    <= {BUSY_CNT_W{1'b0}};
      state_q  <= NORMAL;
      starve_q <= {SCW{1'b0}};
    end else begin
      busy_q   <= busy_d;
      cnt_q    <= cnt_d;
      state_q  <= state_d;
      starve_q <= starve_d;
    end
  end

  assign bus.issue_stall   = stall_s;
  assign bus.mdu_res_ready = ready_s;
  assign bus.busy_cnt      = cnt_q;

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Scoreboard bench: stimulus pushes expected register-file writes into a
// queue; a negedge monitor pops and compares on every rf_we.
module tb_regfile_wb_scheduler;
  import riscv_pkg::*;

  logic clk = 1'b0;
  logic reset;

  regfile_wb_scheduler_if bus ();

  regfile_wb_scheduler dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    reg_idx_t        rd;
    logic [XLEN-1:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  n_pass  = 0;
  int  n_total = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
  endtask

  // Write monitor: every register-file write must match the queue head
  always @(negedge clk) begin
    wr_t e;
    if (bus.rf_we === 1'b1) begin
      n_total++;
      if (exp_q.size() == 0) begin
        $display("FAIL rf_write: got x%0d=0x%0h expected no write", bus.rf_rd, bus.rf_wdata);
      end else begin
        e = exp_q.pop_front();
        if (bus.rf_rd === e.rd && bus.rf_wdata === e.data) n_pass++;
        else $display("FAIL rf_write: got x%0d=0x%0h expected x%0d=0x%0h",
                      bus.rf_rd, bus.rf_wdata, e.rd, e.data);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic iss(input logic v, input int rs1, input int rs2, input int rd, input logic lng);
    bus.issue_valid = v;
    bus.issue_rs1   = reg_idx_t'(rs1);
    bus.issue_rs2   = reg_idx_t'(rs2);
    bus.issue_rd    = reg_idx_t'(rd);
    bus.issue_long  = lng;
  endtask

  task automatic wb(input logic v, input int rd, input logic [63:0] d);
    bus.wb_valid = v;
    bus.wb_rd    = reg_idx_t'(rd);
    bus.wb_data  = d;
  endtask

  task automatic mdu(input logic v, input int rd, input logic [63:0] d);
    bus.mdu_res_valid = v;
    bus.mdu_res_rd    = reg_idx_t'(rd);
    bus.mdu_res_data  = d;
  endtask

  task automatic expect_wr(input int rd, input logic [63:0] d);
    wr_t e;
    e.rd   = reg_idx_t'(rd);
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic idle_in();
    iss(1'b0, 0, 0, 0, 1'b0);
    wb(1'b0, 0, 64'h0);
    mdu(1'b0, 0, 64'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    idle_in();
    wb(1'b1, 3, 64'h99);
    sample();
    check("rst_stall", 64'(bus.issue_stall), 64'd1);
    check("rst_ready", 64'(bus.mdu_res_ready), 64'd0);
    check("rst_we", 64'(bus.rf_we), 64'd0);
    check("rst_busy_cnt", 64'(bus.busy_cnt), 64'd0);
    step(); reset = 1'b0; idle_in();

    // 1: long op to x5, dependent issue stalls until x5 is written
    step(); iss(1'b1, 1, 2, 5, 1'b1); sample();
    check("t1_long_issue", 64'(bus.issue_stall), 64'd0);
    step(); iss(1'b1, 5, 0, 10, 1'b0); sample();
    check("t1_raw_stall", 64'(bus.issue_stall), 64'd1);
    check("t1_busy_cnt", 64'(bus.busy_cnt), 64'd1);
    step(); sample();
    check("t1_raw_hold", 64'(bus.issue_stall), 64'd1);
    step(); mdu(1'b1, 5, 64'h55); expect_wr(5, 64'h55); sample();
    check("t1_res_ready", 64'(bus.mdu_res_ready), 64'd1);
    check("t1_raw_pushcyc", 64'(bus.issue_stall), 64'd1);
    step(); mdu(1'b0, 0, 64'h0); sample();
`ifdef RF_SCHED_BYPASS_EN
    check("t1_byp_stall", 64'(bus.issue_stall), 64'd0);
    check("t1_byp1_hit", 64'(bus.byp1_hit), 64'd1);
    check("t1_byp_data", bus.byp_data, 64'h55);
`else
    check("t1_raw_wrcyc", 64'(bus.issue_stall), 64'd1);
`endif
    check("t1_cnt_wrcyc", 64'(bus.busy_cnt), 64'd1);
    step(); sample();
    check("t1_released", 64'(bus.issue_stall), 64'd0);
    check("t1_cnt_zero", 64'(bus.busy_cnt), 64'd0);

    // 2: WB and MDU result together; WB first, buffered result next
    step(); iss(1'b1, 0, 0, 5, 1'b1); sample();
    check("t2_long_issue", 64'(bus.issue_stall), 64'd0);
    step(); iss(1'b0, 0, 0, 0, 1'b0); wb(1'b1, 3, 64'h7); mdu(1'b1, 5, 64'h2A);
    expect_wr(3, 64'h7); expect_wr(5, 64'h2A); sample();
    step(); wb(1'b0, 0, 64'h0); mdu(1'b0, 0, 64'h0); sample();
    check("t2_cnt_wrcyc", 64'(bus.busy_cnt), 64'd1);
    step(); sample();
    check("t2_cnt_zero", 64'(bus.busy_cnt), 64'd0);

    // 3: four in flight, fifth long op stalls until a retire
    for (int r = 6; r <= 9; r++) begin
      step(); iss(1'b1, 0, 0, r, 1'b1); sample();
      check("t3_fill", 64'(bus.issue_stall), 64'd0);
    end
    step(); iss(1'b1, 0, 0, 10, 1'b1); sample();
    check("t3_full_stall", 64'(bus.issue_stall), 64'd1);
    check("t3_cnt_max", 64'(bus.busy_cnt), 64'd4);
    step(); iss(1'b1, 0, 0, 11, 1'b0); sample();
    check("t3_short_ok", 64'(bus.issue_stall), 64'd0);
    step(); iss(1'b1, 0, 0, 10, 1'b1); mdu(1'b1, 6, 64'h66); expect_wr(6, 64'h66); sample();
    check("t3_full_hold", 64'(bus.issue_stall), 64'd1);
    step(); mdu(1'b0, 0, 64'h0); sample();
    check("t3_full_wrcyc", 64'(bus.issue_stall), 64'd1);
    step(); sample();
    check("t3_fifth_ok", 64'(bus.issue_stall), 64'd0);
    check("t3_cnt_three", 64'(bus.busy_cnt), 64'd3);
    step(); iss(1'b0, 0, 0, 0, 1'b0); sample();
    check("t3_cnt_refill", 64'(bus.busy_cnt), 64'd4);
    for (int k = 0; k < 4; k++) begin
      step(); mdu(1'b1, 7 + k, 64'h70 + 64'(k)); expect_wr(7 + k, 64'h70 + 64'(k)); sample();
      check("t3_drain_ready", 64'(bus.mdu_res_ready), 64'd1);
    end
    step(); mdu(1'b0, 0, 64'h0); sample();
    step(); sample();
    check("t3_cnt_zero", 64'(bus.busy_cnt), 64'd0);

    // 4: WB hogs the port for 10 cycles with one buffered result
    step(); iss(1'b1, 0, 0, 12, 1'b1); sample();
    check("t4_long_issue", 64'(bus.issue_stall), 64'd0);
    for (int w = 1; w <= 10; w++) begin
      step();
      if (w == 1) begin
        iss(1'b1, 1, 0, 13, 1'b0);
        mdu(1'b1, 12, 64'hCC);
      end else begin
        mdu(1'b0, 0, 64'h0);
      end
      wb(1'b1, 1, 64'h100 + 64'(w));
      expect_wr(1, 64'h100 + 64'(w));
      sample();
      check("t4_stall", 64'(bus.issue_stall), (w == 10) ? 64'd1 : 64'd0);
    end
    step(); wb(1'b0, 0, 64'h0); expect_wr(12, 64'hCC); sample();
    check("t4_drain_stall", 64'(bus.issue_stall), 64'd1);
    step(); sample();
    check("t4_normal", 64'(bus.issue_stall), 64'd0);

    // 5: reset with two ops in flight; late results are dropped
    step(); iss(1'b1, 0, 0, 14, 1'b1); sample();
    check("t5_issue_a", 64'(bus.issue_stall), 64'd0);
    step(); iss(1'b1, 0, 0, 15, 1'b1); sample();
    check("t5_issue_b", 64'(bus.issue_stall), 64'd0);
    step(); iss(1'b0, 0, 0, 0, 1'b0); sample();
    check("t5_cnt_two", 64'(bus.busy_cnt), 64'd2);
    step(); reset = 1'b1; sample();
    check("t5_rst_cnt", 64'(bus.busy_cnt), 64'd0);
    check("t5_rst_ready", 64'(bus.mdu_res_ready), 64'd0);
    step(); reset = 1'b0; mdu(1'b1, 14, 64'hE1); sample();
    check("t5_ready_a", 64'(bus.mdu_res_ready), 64'd1);
    step(); mdu(1'b1, 15, 64'hE2); sample();
    check("t5_ready_b", 64'(bus.mdu_res_ready), 64'd1);
    step(); mdu(1'b0, 0, 64'h0); iss(1'b1, 14, 15, 16, 1'b0); sample();
    check("t5_no_hazard", 64'(bus.issue_stall), 64'd0);
    step(); iss(1'b0, 0, 0, 0, 1'b0); sample();
    check("t5_cnt_zero", 64'(bus.busy_cnt), 64'd0);

    // 6: long op to x0 and WB to x0 never write
    step(); iss(1'b1, 0, 0, 0, 1'b1); sample();
    check("t6_issue_x0", 64'(bus.issue_stall), 64'd0);
    step(); iss(1'b0, 0, 0, 0, 1'b0); mdu(1'b1, 0, 64'hDEAD); sample();
    check("t6_cnt_zero", 64'(bus.busy_cnt), 64'd0);
    step(); mdu(1'b0, 0, 64'h0); sample();
    step(); wb(1'b1, 0, 64'h55); sample();
    check("t6_wb_x0", 64'(bus.rf_we), 64'd0);
    step(); idle_in(); sample();
    check("t6_cnt_end", 64'(bus.busy_cnt), 64'd0);

    repeat (3) step();
    check("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
